// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA timing generator with a built-in test-pattern mux. It
// divides CLOCK_50 down to a pixel strobe and runs horizontal and vertical
// counters. Each line and each frame is ordered sync, back porch, active,
// front porch. The generator exposes the active pixel coordinates so an
// external renderer can supply colour. It also drives an ADV7123-style DAC:
// pixel clock, syncs, blank and 8-bit RGB.
//
// Ports
//   CLOCK_50     in   system clock, all logic on its rising edge
//   RESET_N      in   asynchronous active-low reset
//   MODE[1:0]    in   0 external, 1 solid, 2 colour bars, 3 checkerboard
//   PIX_RGB[23:0] in  external pixel {R,G,B}, sampled on PIX_CE while PIX_REQ
//   PIX_REQ      out  counters are inside active video
//   PIX_X[10:0]  out  active column, 0 outside active video
//   PIX_Y[9:0]   out  active row, 0 outside active video
//   PIX_CE       out  one-cycle pixel strobe
//   FRAME_START  out  PIX_CE at h=0, v=0
//   LINE_START   out  PIX_CE at h=0
//   VGA_CLK      out  DAC pixel clock
//   VGA_HS/VS    out  sync outputs, polarity set by H_POL/V_POL
//   VGA_BLANK_N  out  high during active video
//   VGA_SYNC_N   out  tied low
//   VGA_R/G/B    out  8-bit colour channels
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int          CLK_DIV   = 2,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter logic        H_POL     = 1'b0,
    parameter logic        V_POL     = 1'b0,
    parameter logic [23:0] SOLID_RGB = 24'h3DD198
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [1:0]  MODE,
    input  logic [23:0] PIX_RGB,
    output logic        PIX_REQ,
    output logic [10:0] PIX_X,
    output logic [9:0]  PIX_Y,
    output logic        PIX_CE,
    output logic        FRAME_START,
    output logic        LINE_START,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    // Guard against a zero bar width on very narrow test configurations.
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [10:0]      H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0]      H_SYNC_E  = 11'(H_SYNC);
    localparam logic [10:0]      H_ACT_BEG = 11'(H_SYNC + H_BP);
    localparam logic [10:0]      H_ACT_END = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_SYNC_E  = 10'(V_SYNC);
    localparam logic [9:0]       V_ACT_BEG = 10'(V_SYNC + V_BP);
    localparam logic [9:0]       V_ACT_END = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0]      BAR_W_L   = 11'(BAR_W);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             pix_ce;
    logic [10:0]      h_cnt;
    logic [9:0]       v_cnt;
    logic             active;
    logic [10:0]      pix_x;
    logic [9:0]       pix_y;
    logic             line_start;
    logic             frame_start;
    logic [1:0]       mode_q;
    logic [10:0]      bar_raw;
    logic [2:0]       bar_idx;
    logic [23:0]      colour;

    assign pix_ce      = (div_cnt == DIV_LAST);
    assign div_next    = pix_ce ? '0 : div_cnt + DIV_W'(1);
    assign active      = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
                         (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    assign pix_x       = active ? (h_cnt - H_ACT_BEG) : 11'd0;
    assign pix_y       = active ? (v_cnt - V_ACT_BEG) : 10'd0;
    assign line_start  = pix_ce && (h_cnt == 11'd0);
    assign frame_start = line_start && (v_cnt == 10'd0);

    assign PIX_CE      = pix_ce;
    assign PIX_REQ     = active;
    assign PIX_X       = pix_x;
    assign PIX_Y       = pix_y;
    assign LINE_START  = line_start;
    assign FRAME_START = frame_start;
    assign VGA_SYNC_N  = 1'b0;

    // VGA_CLK is built from the next divider value, so after each edge it
    // reads "div_cnt >= CLK_DIV/2". Its rising edge therefore lands
    // mid-period, while the DAC data only moves on the strobe boundary.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            div_cnt <= div_next;
            VGA_CLK <= (div_next >= DIV_HALF);
        end
    end

    // The raster counters step once per pixel strobe.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST)
                    v_cnt <= '0;
                else
                    v_cnt <= v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // The mode is only taken at the frame origin, so a frame never mixes
    // two patterns.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            mode_q <= 2'd0;
        else if (frame_start)
            mode_q <= MODE;
    end

    // The last bar absorbs any remainder when H_ACTIVE is not a multiple of 8.
    always_comb begin
        colour  = 24'h000000;
        bar_raw = pix_x / BAR_W_L;
        bar_idx = (bar_raw > 11'd7) ? 3'd7 : bar_raw[2:0];
        case (mode_q)
            2'd0: colour = PIX_RGB;
            2'd1: colour = SOLID_RGB;
            2'd2: begin
                case (bar_idx)
                    3'd0:    colour = 24'hFFFFFF;
                    3'd1:    colour = 24'hFFFF00;
                    3'd2:    colour = 24'h00FFFF;
                    3'd3:    colour = 24'h00FF00;
                    3'd4:    colour = 24'hFF00FF;
                    3'd5:    colour = 24'hFF0000;
                    3'd6:    colour = 24'h0000FF;
                    default: colour = 24'h000000;
                endcase
            end
            default: colour = (pix_x[5] ^ pix_y[5]) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

    // The DAC-side outputs register the current position on the strobe,
    // which gives every output the same one-pixel latency.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_HS                <= ~H_POL;
            VGA_VS                <= ~V_POL;
            VGA_BLANK_N           <= 1'b0;
            {VGA_R, VGA_G, VGA_B} <= 24'h000000;
        end else if (pix_ce) begin
            VGA_HS                <= (h_cnt < H_SYNC_E) ? H_POL : ~H_POL;
            VGA_VS                <= (v_cnt < V_SYNC_E) ? V_POL : ~V_POL;
            VGA_BLANK_N           <= active;
            {VGA_R, VGA_G, VGA_B} <= active ? colour : 24'h000000;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Testbench for vga_timing_gen. It uses two instances:
//   dut   - compact raster, 84 active pixels by 36 active lines, CLK_DIV=2.
//           It checks every cycle against a reference built from an
//           elapsed-cycle counter. A scoreboard holds the expected DAC word
//           for each pixel.
//   dut_s - small override with CLK_DIV=4, H=8/4/16/4, V=1/1/4/1 and
//           active-high syncs. It is checked by measuring pulse widths and
//           counting events.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int CD  = 2;
    localparam int HSY = 8;
    localparam int HBP = 4;
    localparam int HAC = 84;
    localparam int HFP = 4;
    localparam int HT  = HSY + HBP + HAC + HFP;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int VAC = 36;
    localparam int VFP = 1;
    localparam int VT  = VSY + VBP + VAC + VFP;
    localparam int FR  = CD * HT * VT;

    localparam int SCD     = 4;
    localparam int S_FRAME = 896;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
    } reg_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [1:0]  mode   = 2'd0;
    logic [1:0]  mode_s = 2'd1;
    logic [23:0] pix_rgb;
    logic [23:0] pix_rgb_s = 24'h000000;

    logic        pix_req, pix_ce, frame_start, line_start;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        vga_clk, vga_hs, vga_vs, blank_n, sync_n;
    logic [7:0]  r, g, b;

    logic        pix_req_s, pix_ce_s, frame_start_s, line_start_s;
    logic [10:0] pix_x_s;
    logic [9:0]  pix_y_s;
    logic        vga_clk_s, vga_hs_s, vga_vs_s, blank_n_s, sync_n_s;
    logic [7:0]  r_s, g_s, b_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // The external source echoes the requested coordinates back.
    assign pix_rgb = {pix_x[7:0], pix_y[7:0], 8'hA5};

    vga_timing_gen #(
        .CLK_DIV(CD), .H_SYNC(HSY), .H_BP(HBP), .H_ACTIVE(HAC), .H_FP(HFP),
        .V_SYNC(VSY), .V_BP(VBP), .V_ACTIVE(VAC), .V_FP(VFP),
        .H_POL(1'b0), .V_POL(1'b0), .SOLID_RGB(24'h3DD198)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .MODE(mode), .PIX_RGB(pix_rgb),
        .PIX_REQ(pix_req), .PIX_X(pix_x), .PIX_Y(pix_y), .PIX_CE(pix_ce),
        .FRAME_START(frame_start), .LINE_START(line_start), .VGA_CLK(vga_clk),
        .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(blank_n),
        .VGA_SYNC_N(sync_n), .VGA_R(r), .VGA_G(g), .VGA_B(b)
    );

    vga_timing_gen #(
        .CLK_DIV(SCD), .H_SYNC(8), .H_BP(4), .H_ACTIVE(16), .H_FP(4),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .H_POL(1'b1), .V_POL(1'b1), .SOLID_RGB(24'h3DD198)
    ) dut_s (
        .CLOCK_50(clk), .RESET_N(rst_n), .MODE(mode_s), .PIX_RGB(pix_rgb_s),
        .PIX_REQ(pix_req_s), .PIX_X(pix_x_s), .PIX_Y(pix_y_s), .PIX_CE(pix_ce_s),
        .FRAME_START(frame_start_s), .LINE_START(line_start_s), .VGA_CLK(vga_clk_s),
        .VGA_HS(vga_hs_s), .VGA_VS(vga_vs_s), .VGA_BLANK_N(blank_n_s),
        .VGA_SYNC_N(sync_n_s), .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s)
    );

    // Reference raster position, derived from cycles elapsed since reset.
    int         cyc;
    logic [1:0] mode_m;
    int         m_div, m_h, m_v, m_x, m_y;
    logic       m_ce, m_act;
    reg_t       sb_q[$];

    always_comb begin
        m_div = cyc % CD;
        m_h   = (cyc / CD) % HT;
        m_v   = ((cyc / CD) / HT) % VT;
        m_ce  = (m_div == CD - 1);
        m_act = (m_h >= HSY + HBP) && (m_h < HSY + HBP + HAC) &&
                (m_v >= VSY + VBP) && (m_v < VSY + VBP + VAC);
        m_x   = m_act ? m_h - (HSY + HBP) : 0;
        m_y   = m_act ? m_v - (VSY + VBP) : 0;
    end

    function automatic logic [23:0] exp_colour(int x, int y, logic [1:0] md);
        logic [23:0] c;
        logic [10:0] xv;
        logic [9:0]  yv;
        int          idx;
        xv  = 11'(x);
        yv  = 10'(y);
        idx = x / (HAC / 8);
        if (idx > 7) idx = 7;
        c = 24'h000000;
        case (md)
            2'd0: c = {xv[7:0], yv[7:0], 8'hA5};
            2'd1: c = 24'h3DD198;
            2'd2: begin
                case (idx)
                    0: c = 24'hFFFFFF;
                    1: c = 24'hFFFF00;
                    2: c = 24'h00FFFF;
                    3: c = 24'h00FF00;
                    4: c = 24'hFF00FF;
                    5: c = 24'hFF0000;
                    6: c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            default: c = (xv[5] ^ yv[5]) ? 24'hFFFFFF : 24'h000000;
        endcase
        return c;
    endfunction

    function automatic reg_t exp_reg(int h, int v, int x, int y, logic act, logic [1:0] md);
        reg_t e;
        e.hs    = (h < HSY) ? 1'b0 : 1'b1;
        e.vs    = (v < VSY) ? 1'b0 : 1'b1;
        e.blank = act;
        e.rgb   = act ? exp_colour(x, y, md) : 24'h000000;
        return e;
    endfunction

    // Each strobe pushes the DAC word that must appear for the next period.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    <= 0;
            mode_m <= 2'd0;
            sb_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (m_ce) begin
                sb_q.push_back(exp_reg(m_h, m_v, m_x, m_y, m_act, mode_m));
                if (m_h == 0 && m_v == 0) mode_m <= mode;
            end
        end
    end

    task automatic test_reset();
        logic [26:0] got;
        rst_n = 1'b0;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        got = {vga_hs, vga_vs, blank_n, r, g, b};
        if (got !== {3'b110, 24'h000000}) begin
            failures++;
            $display("[TB] FAIL reset_reg got=%h exp=%h", got, {3'b110, 24'h000000});
        end
        checks++;
        if ({vga_clk, pix_ce, pix_req, pix_x, pix_y, sync_n} !== 25'd0) begin
            failures++;
            $display("[TB] FAIL reset_comb got=%h exp=0", {vga_clk, pix_ce, pix_req, pix_x, pix_y, sync_n});
        end
        checks++;
        got = {vga_hs_s, vga_vs_s, blank_n_s, r_s, g_s, b_s};
        if ({got, vga_clk_s} !== 28'd0) begin
            failures++;
            $display("[TB] FAIL reset_small got=%h exp=0", {got, vga_clk_s});
        end
        checks++;
        rst_n = 1'b1;
        if (pix_ce !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_ce0 got=%b exp=0", pix_ce);
        end
        checks++;
        @(negedge clk);
        if ({pix_ce, frame_start, line_start, vga_clk} !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL release_first_strobe got=%b exp=1111", {pix_ce, frame_start, line_start, vga_clk});
        end
        checks++;
        repeat (2) @(negedge clk);
        if ({pix_ce_s, frame_start_s} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL release_small_strobe got=%b exp=11", {pix_ce_s, frame_start_s});
        end
        checks++;
    endtask

    // MODE schedule: 1, 2 (switched to 3 mid-frame), then 0. Each displayed
    // frame shows the mode held at its start.
    task automatic test_modes();
        int          step_mode [6] = '{1, 2, 2, 3, 0, 0};
        int          step_len  [6] = '{FR, FR, FR / 2, FR / 2, FR, FR};
        logic [26:0] got_c, exp_c;
        reg_t        got_r, exp_r;
        @(negedge clk);
        sb_q.delete();
        for (int s = 0; s < 6; s++) begin
            mode = 2'(step_mode[s]);
            for (int c = 0; c < step_len[s]; c++) begin
                @(negedge clk);
                got_c = {pix_ce, pix_req, line_start, frame_start, vga_clk, sync_n, pix_x, pix_y};
                exp_c = {m_ce, m_act, m_ce && (m_h == 0), m_ce && (m_h == 0) && (m_v == 0),
                         (m_div >= CD / 2), 1'b0, 11'(m_x), 10'(m_y)};
                if (got_c !== exp_c) begin
                    failures++;
                    $display("[TB] FAIL comb cyc=%0d got=%h exp=%h", cyc, got_c, exp_c);
                end
                checks++;
                if (m_ce && sb_q.size() > 0) begin
                    exp_r = sb_q.pop_front();
                    got_r = {vga_hs, vga_vs, blank_n, r, g, b};
                    if (got_r !== exp_r) begin
                        failures++;
                        $display("[TB] FAIL pixel cyc=%0d mode=%0d got=%h exp=%h", cyc, mode_m, got_r, exp_r);
                    end
                    checks++;
                end
            end
        end
    endtask

    task automatic test_override();
        int   n = 0, fs_cnt = 0, ls_cnt = 0, hs_hi = 0, vs_hi = 0;
        int   blank_cyc = 0, solid_cyc = 0, zero_cyc = 0;
        int   ls_first = -1, ls_second = -1, run = 0, last_run = 0;
        logic e_clk;
        while (frame_start_s !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            failures++;
            $display("[TB] FAIL small_frame_wait got=timeout exp=FRAME_START");
        end
        checks++;
        for (int k = 0; k < S_FRAME; k++) begin
            fs_cnt    += int'(frame_start_s);
            ls_cnt    += int'(line_start_s);
            hs_hi     += int'(vga_hs_s);
            vs_hi     += int'(vga_vs_s);
            blank_cyc += int'(blank_n_s);
            if ({r_s, g_s, b_s} == 24'h3DD198) solid_cyc++;
            if ({r_s, g_s, b_s} == 24'h000000) zero_cyc++;
            if (line_start_s) begin
                if (ls_first < 0) ls_first = k;
                else if (ls_second < 0) ls_second = k;
            end
            if (vga_hs_s) run++;
            else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            e_clk = (((k + SCD - 1) % SCD) >= SCD / 2);
            if (vga_clk_s !== e_clk) begin
                failures++;
                $display("[TB] FAIL small_vga_clk k=%0d got=%b exp=%b", k, vga_clk_s, e_clk);
            end
            checks++;
            @(negedge clk);
        end
        if (fs_cnt != 1) begin failures++; $display("[TB] FAIL small_frame_starts got=%0d exp=1", fs_cnt); end
        checks++;
        if (ls_cnt != 7) begin failures++; $display("[TB] FAIL small_line_starts got=%0d exp=7", ls_cnt); end
        checks++;
        if (ls_second - ls_first != 128) begin failures++; $display("[TB] FAIL small_line_period got=%0d exp=128", ls_second - ls_first); end
        checks++;
        if (hs_hi != 224) begin failures++; $display("[TB] FAIL small_hs_high got=%0d exp=224", hs_hi); end
        checks++;
        if (last_run != 32) begin failures++; $display("[TB] FAIL small_hs_run got=%0d exp=32", last_run); end
        checks++;
        if (vs_hi != 128) begin failures++; $display("[TB] FAIL small_vs_high got=%0d exp=128", vs_hi); end
        checks++;
        if (blank_cyc != 256) begin failures++; $display("[TB] FAIL small_blank got=%0d exp=256", blank_cyc); end
        checks++;
        if (solid_cyc != 256) begin failures++; $display("[TB] FAIL small_solid got=%0d exp=256", solid_cyc); end
        checks++;
        if (zero_cyc != 640) begin failures++; $display("[TB] FAIL small_black got=%0d exp=640", zero_cyc); end
        checks++;
    endtask

    task automatic test_async_reset();
        int n = 0, lowc = 0;
        while (!(m_act && m_x == 20 && m_y == 10) && n < 2 * FR) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FR) begin
            failures++;
            $display("[TB] FAIL areset_wait got=timeout exp=active");
        end
        checks++;
        if (blank_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL areset_pre_blank got=%b exp=1", blank_n);
        end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if ({vga_hs, vga_vs, blank_n, r, g, b} !== {3'b110, 24'h000000}) begin
            failures++;
            $display("[TB] FAIL areset_reg got=%h exp=%h", {vga_hs, vga_vs, blank_n, r, g, b}, {3'b110, 24'h000000});
        end
        checks++;
        if ({vga_clk, pix_ce, pix_req, pix_x, pix_y, line_start, frame_start} !== 26'd0) begin
            failures++;
            $display("[TB] FAIL areset_comb got=%h exp=0", {vga_clk, pix_ce, pix_req, pix_x, pix_y, line_start, frame_start});
        end
        checks++;
        if ({vga_hs_s, vga_vs_s, blank_n_s, r_s, g_s, b_s, vga_clk_s} !== 28'd0) begin
            failures++;
            $display("[TB] FAIL areset_small got=%h exp=0", {vga_hs_s, vga_vs_s, blank_n_s, r_s, g_s, b_s, vga_clk_s});
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if ({pix_ce, frame_start} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL areset_restart got=%b exp=11", {pix_ce, frame_start});
        end
        checks++;
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (!vga_hs) lowc++;
            else if (lowc > 0) break;
        end
        if (lowc != HSY * CD) begin
            failures++;
            $display("[TB] FAIL areset_hs_low got=%0d exp=%0d", lowc, HSY * CD);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_override();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
